tile_resolve: RTL and testbench

Tile writeback engine directly downstream of the on-chip tile buffer in the mobile tiler/ROP path. When a tile completes, it streams all pixels out of the tile buffer's registered read port. It packs them into fixed-length write bursts to the memory subsystem, with one command per burst plus a data beat stream, and can optionally clear each pixel to a constant as it is read. While busy, the block owns the tile buffer. The external write-port mux selects this block's write port whenever `busy`=1.

---
 rtl/tile_resolve_if.sv | 41 ++++
 rtl/tile_resolve.sv | 133 +++++++++++++
 tb/tb_tile_resolve.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_resolve_if.sv
// Tile-buffer and memory-write ports of the tile resolve engine.
// master = resolve engine, slave = tile buffer / memory side.
interface tile_resolve_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MADDR_W = 32
);
  logic              tb_rd_en;
  logic [ADDR_W-1:0] tb_rd_addr;
  logic [DATA_W-1:0] tb_rd_data;
  logic              tb_wr_en;
  logic [ADDR_W-1:0] tb_wr_addr;
  logic [DATA_W-1:0] tb_wr_data;

  logic               mem_cmd_valid;
  logic               mem_cmd_ready;
  logic [MADDR_W-1:0] mem_cmd_addr;
  logic [7:0]         mem_cmd_len;
  logic               mem_wdata_valid;
  logic               mem_wdata_ready;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_wdata_last;

  modport master (
    output tb_rd_en, tb_rd_addr, tb_wr_en, tb_wr_addr, tb_wr_data,
    input  tb_rd_data,
    output mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
    input  mem_cmd_ready,
    output mem_wdata_valid, mem_wdata, mem_wdata_last,
    input  mem_wdata_ready
  );

  modport slave (
    input  tb_rd_en, tb_rd_addr, tb_wr_en, tb_wr_addr, tb_wr_data,
    output tb_rd_data,
    input  mem_cmd_valid, mem_cmd_addr, mem_cmd_len,
    output mem_cmd_ready,
    input  mem_wdata_valid, mem_wdata, mem_wdata_last,
    output mem_wdata_ready
  );
endinterface

// File: rtl/tile_resolve.sv
// Tile resolve engine: streams a tile out of the tile buffer into fixed-length memory
// write bursts, optionally clearing each pixel as it is read.
module tile_resolve #(
  parameter int unsigned TILE_PIXELS = 1024,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = $clog2(TILE_PIXELS),
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned MADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MADDR_W-1:0] base_addr,
  input  logic               clear_en,
  input  logic [DATA_W-1:0]  clear_val,
  output logic               busy,
  output logic               done,
  tile_resolve_if.master     bus
);

  localparam int unsigned PtrW = ADDR_W + 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN);
  localparam logic [MADDR_W-1:0] BurstBytes = MADDR_W'(BURST_LEN * (DATA_W / 8));

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCmd  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [PtrW-1:0]    rd_ptr_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               inflight_q;
  logic [DATA_W-1:0]  fifo_q [3];
  logic [1:0]         wr_idx_q, rd_idx_q, count_q;
  logic [BeatW-1:0]   beat_q;
  logic [PtrW-1:0]    out_cnt_q;
  logic [MADDR_W-1:0] cmd_addr_q;
  logic               clear_en_q;
  logic [DATA_W-1:0]  clear_val_q;
  logic               done_q;

  logic accept, rd_en, push, pop, cmd_hs, beat_last, final_hs;

  function automatic logic [1:0] idx_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    busy      = (state_q != StIdle);
    accept    = (state_q == StIdle) && start;
    // Read budget counts the read already in flight so the 3-entry FIFO never overflows.
    rd_en     = busy && (rd_ptr_q < PtrW'(TILE_PIXELS)) &&
                ((3'(count_q) + 3'(inflight_q)) < 3'd3);
    push      = inflight_q;
    cmd_hs    = (state_q == StCmd) && bus.mem_cmd_ready;
    pop       = (state_q == StData) && (count_q != 2'd0) && bus.mem_wdata_ready;
    beat_last = (beat_q == BeatW'(BURST_LEN - 1));
    final_hs  = pop && (out_cnt_q == PtrW'(TILE_PIXELS - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StCmd;
      StCmd:   if (cmd_hs) state_d = StData;
      StData:  if (pop && beat_last) state_d = final_hs ? StIdle : StCmd;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      rd_addr_q   <= '0;
      inflight_q  <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      out_cnt_q   <= '0;
      cmd_addr_q  <= '0;
      clear_en_q  <= 1'b0;
      clear_val_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_en;
      done_q     <= final_hs;
      count_q    <= count_q + 2'(push) - 2'(pop);
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        rd_addr_q <= rd_ptr_q[ADDR_W-1:0];
      end
      if (push) wr_idx_q <= idx_next(wr_idx_q);
      if (pop) begin
        rd_idx_q  <= idx_next(rd_idx_q);
        beat_q    <= beat_last ? '0 : beat_q + BeatW'(1);
        out_cnt_q <= out_cnt_q + PtrW'(1);
      end
      if (cmd_hs) cmd_addr_q <= cmd_addr_q + BurstBytes;
      if (accept) begin
        rd_ptr_q    <= '0;
        out_cnt_q   <= '0;
        beat_q      <= '0;
        cmd_addr_q  <= base_addr;
        clear_en_q  <= clear_en;
        clear_val_q <= clear_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_idx_q] <= bus.tb_rd_data;
  end

  always_comb begin
    done                = done_q;
    bus.tb_rd_en        = rd_en;
    bus.tb_rd_addr      = rd_ptr_q[ADDR_W-1:0];
    // Clear the pixel in the same cycle its read data is captured.
    bus.tb_wr_en        = inflight_q && clear_en_q;
    bus.tb_wr_addr      = rd_addr_q;
    bus.tb_wr_data      = clear_val_q;
    bus.mem_cmd_valid   = (state_q == StCmd);
    bus.mem_cmd_addr    = cmd_addr_q;
    bus.mem_cmd_len     = 8'(BURST_LEN - 1);
    bus.mem_wdata_valid = (state_q == StData) && (count_q != 2'd0);
    bus.mem_wdata       = fifo_q[rd_idx_q];
    bus.mem_wdata_last  = bus.mem_wdata_valid && beat_last;
  end

endmodule

// File: tb/tb_tile_resolve.sv
// Self-checking bench for tile_resolve: scoreboard of expected commands and beats,
// tile buffer model with registered read port, scenario tasks run in sequence.
module tb_tile_resolve;

  localparam int unsigned NPIX = 64;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic        clear_en;
  logic [31:0] clear_val;
  logic        busy;
  logic        done;

  logic        cmd_ready   = 1'b1;
  logic        wdata_ready = 1'b1;
  logic        rand_mode   = 1'b0;
  logic        fill_req    = 1'b0;
  logic [31:0] rd_data;
  logic [31:0] tbuf [NPIX];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_cmd [$];
  logic [32:0] exp_data [$];
  logic [31:0] cur_clear_val;

  int cmd_hs_cnt  = 0;
  int beats_seen  = 0;
  int rd_issued   = 0;
  int wr_cnt      = 0;
  int done_cnt    = 0;
  logic        prev_cmd_stall = 1'b0;
  logic        prev_w_stall   = 1'b0;
  logic [31:0] prev_cmd_addr;
  logic [32:0] prev_w;

  tile_resolve_if #(.DATA_W(32), .ADDR_W(6), .MADDR_W(32)) bus ();

  tile_resolve #(
    .TILE_PIXELS(NPIX), .DATA_W(32), .ADDR_W(6), .BURST_LEN(16), .MADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .clear_en(clear_en),
    .clear_val(clear_val), .busy(busy), .done(done), .bus(bus)
  );

  assign bus.mem_cmd_ready   = cmd_ready;
  assign bus.mem_wdata_ready = wdata_ready;
  assign bus.tb_rd_data      = rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile buffer model: registered read port plus clear write port.
  always @(posedge clk) begin
    if (bus.tb_rd_en) rd_data <= tbuf[bus.tb_rd_addr];
    if (fill_req) begin
      for (int i = 0; i < NPIX; i++) tbuf[i] <= 32'(i);
    end else if (bus.tb_wr_en) begin
      tbuf[bus.tb_wr_addr] <= bus.tb_wr_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) wdata_ready = ($urandom_range(0, 99) < 30);
    else wdata_ready = 1'b1;
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_cmd.delete();
      exp_data.delete();
      cmd_hs_cnt = 0; beats_seen = 0; rd_issued = 0; wr_cnt = 0; done_cnt = 0;
      prev_cmd_stall = 1'b0;
      prev_w_stall = 1'b0;
    end else begin
      checks++;
      if (bus.mem_cmd_valid && bus.mem_wdata_valid) begin
        errors++;
        $display("FAIL cmd_wdata_overlap: both valid at t=%0t", $time);
      end
      if (prev_cmd_stall) begin
        checks++;
        if (bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_addr !== prev_cmd_addr) begin
          errors++;
          $display("FAIL cmd_hold: valid=%b addr=%h, required valid=1 addr=%h",
                   bus.mem_cmd_valid, bus.mem_cmd_addr, prev_cmd_addr);
        end
      end
      if (prev_w_stall) begin
        checks++;
        if (bus.mem_wdata_valid !== 1'b1 || {bus.mem_wdata_last, bus.mem_wdata} !== prev_w) begin
          errors++;
          $display("FAIL wdata_hold: valid=%b beat=%h, required valid=1 beat=%h",
                   bus.mem_wdata_valid, {bus.mem_wdata_last, bus.mem_wdata}, prev_w);
        end
      end
      checks++;
      if (rd_issued - beats_seen > 3) begin
        errors++;
        $display("FAIL fifo_bound: outstanding=%0d, required <=3", rd_issued - beats_seen);
      end
      if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
        checks++;
        if (exp_cmd.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: addr=%h, required no command", bus.mem_cmd_addr);
        end else begin
          logic [31:0] ea;
          ea = exp_cmd.pop_front();
          if (bus.mem_cmd_addr !== ea || bus.mem_cmd_len !== 8'd15) begin
            errors++;
            $display("FAIL cmd: addr=%h len=%0d, required addr=%h len=15",
                     bus.mem_cmd_addr, bus.mem_cmd_len, ea);
          end
        end
        cmd_hs_cnt++;
      end
      if (bus.mem_wdata_valid && bus.mem_wdata_ready) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: data=%h, required no beat", bus.mem_wdata);
        end else begin
          logic [32:0] eb;
          eb = exp_data.pop_front();
          if ({bus.mem_wdata_last, bus.mem_wdata} !== eb) begin
            errors++;
            $display("FAIL beat: last/data=%h, required %h", {bus.mem_wdata_last, bus.mem_wdata}, eb);
          end
        end
        beats_seen++;
      end
      if (bus.tb_wr_en) begin
        checks++;
        if (bus.tb_wr_addr !== 6'(wr_cnt) || bus.tb_wr_data !== cur_clear_val) begin
          errors++;
          $display("FAIL clear_write: addr=%0d data=%h, required addr=%0d data=%h",
                   bus.tb_wr_addr, bus.tb_wr_data, wr_cnt % NPIX, cur_clear_val);
        end
        wr_cnt++;
      end
      if (done) done_cnt++;
      if (bus.tb_rd_en) rd_issued++;
      prev_cmd_stall = bus.mem_cmd_valid && !bus.mem_cmd_ready;
      prev_cmd_addr  = bus.mem_cmd_addr;
      prev_w_stall   = bus.mem_wdata_valid && !bus.mem_wdata_ready;
      prev_w         = {bus.mem_wdata_last, bus.mem_wdata};
    end
  end

  task automatic fill_tile();
    fill_req = 1'b1;
    @(posedge clk); #1;
    fill_req = 1'b0;
  endtask

  // Pushes the expected commands/beats and pulses start over one edge.
  task automatic kick(input logic [31:0] b, input logic ce, input logic [31:0] cv);
    for (int k = 0; k < 4; k++) exp_cmd.push_back(b + 32'(k * 64));
    for (int i = 0; i < NPIX; i++) exp_data.push_back({(i % 16) == 15, 32'(i)});
    cur_clear_val = cv;
    base_addr = b; clear_en = ce; clear_val = cv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, bus.tb_rd_en, bus.tb_wr_en, bus.mem_cmd_valid, bus.mem_wdata_valid,
         bus.mem_wdata_last} !== 7'b0 || bus.tb_rd_addr !== 6'd0 || bus.mem_cmd_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ctl=%b rd_addr=%0d cmd_addr=%h, required all zero",
               {busy, done, bus.tb_rd_en, bus.tb_wr_en, bus.mem_cmd_valid,
                bus.mem_wdata_valid, bus.mem_wdata_last}, bus.tb_rd_addr, bus.mem_cmd_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit ok; int d0;
    fill_tile();
    d0 = done_cnt;
    kick(32'h1000, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (!(busy && bus.mem_cmd_valid && bus.tb_rd_en) || bus.mem_cmd_addr !== 32'h1000 ||
        bus.tb_rd_addr !== 6'd0) begin
      errors++;
      $display("FAIL first_cycle: busy=%b cv=%b rd=%b addr=%h rd_addr=%0d, required 1 1 1 1000 0",
               busy, bus.mem_cmd_valid, bus.tb_rd_en, bus.mem_cmd_addr, bus.tb_rd_addr);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_wdata_valid !== 1'b0) begin
      errors++;
      $display("FAIL beat_early: wvalid=%b in cycle 2, required 0", bus.mem_wdata_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_wdata_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_beat: wvalid=%b in cycle 3, required 1", bus.mem_wdata_valid);
    end
    wait_done(cyc, ok);
    checks++;
    if (!ok || cyc + 3 != 70) begin
      errors++;
      $display("FAIL basic_latency: done_seen=%b cycle=%0d, required 1 at cycle 70", ok, cyc + 3);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done: busy=%b, required 0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL done_pulse: done=%b pulses=%0d, required 0 and 1", done, done_cnt - d0);
    end
    checks++;
    if (exp_cmd.size() != 0 || exp_data.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: cmds left=%0d beats left=%0d, required 0 0",
               exp_cmd.size(), exp_data.size());
    end
  endtask

  task automatic test_clear();
    int cyc; bit ok; int w0; int bad;
    fill_tile();
    w0 = wr_cnt;
    kick(32'h1000, 1'b1, 32'hDEADBEEF);
    wait_done(cyc, ok);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (tbuf[i] !== 32'hDEADBEEF) bad++;
    checks++;
    if (!ok || bad != 0 || wr_cnt - w0 != NPIX || exp_data.size() != 0) begin
      errors++;
      $display("FAIL clear: done=%b uncleared=%0d writes=%0d beats_left=%0d, required 1 0 64 0",
               ok, bad, wr_cnt - w0, exp_data.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit ok;
    fill_tile();
    rand_mode = 1'b1;
    kick(32'h4000, 1'b0, 32'h0);
    wait_done(cyc, ok);
    rand_mode = 1'b0;
    checks++;
    if (!ok || exp_data.size() != 0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL backpressure: done=%b beats_left=%0d cmds_left=%0d, required 1 0 0",
               ok, exp_data.size(), exp_cmd.size());
    end
  endtask

  task automatic test_cmd_stall();
    int cyc; bit ok; bit seen; int c0;
    fill_tile();
    c0 = cmd_hs_cnt;
    kick(32'h1000, 1'b0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (cmd_hs_cnt - c0 == 2) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_ready = 1'b0;
    for (int i = 0; i < 100 && !bus.mem_cmd_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (!seen || bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_addr !== 32'h1080 ||
          bus.mem_wdata_valid !== 1'b0) begin
        errors++;
        $display("FAIL cmd_stall: reached=%b cv=%b addr=%h wv=%b, required 1 1 1080 0",
                 seen, bus.mem_cmd_valid, bus.mem_cmd_addr, bus.mem_wdata_valid);
      end
    end
    @(posedge clk); #1;
    cmd_ready = 1'b1;
    wait_done(cyc, ok);
    checks++;
    if (!ok || exp_data.size() != 0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL cmd_stall_drain: done=%b beats_left=%0d cmds_left=%0d, required 1 0 0",
               ok, exp_data.size(), exp_cmd.size());
    end
  endtask

  task automatic test_wrap();
    int cyc; bit ok;
    fill_tile();
    kick(32'hFFFFFFC0, 1'b0, 32'h0);
    wait_done(cyc, ok);
    checks++;
    if (!ok || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL wrap: done=%b cmds_left=%0d, required 1 0", ok, exp_cmd.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; bit hit;
    fill_tile();
    kick(32'h8000, 1'b1, 32'h0BADF00D);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (beats_seen >= 20) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!hit || {busy, done, bus.tb_rd_en, bus.tb_wr_en, bus.mem_cmd_valid,
                 bus.mem_wdata_valid, bus.mem_wdata_last} !== 7'b0 ||
        bus.tb_rd_addr !== 6'd0 || bus.mem_cmd_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: reached=%b ctl=%b rd_addr=%0d cmd_addr=%h, required 1 and zeros",
               hit, {busy, done, bus.tb_rd_en, bus.tb_wr_en, bus.mem_cmd_valid,
                     bus.mem_wdata_valid, bus.mem_wdata_last}, bus.tb_rd_addr, bus.mem_cmd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    fill_tile();
    kick(32'h9000, 1'b0, 32'h0);
    wait_done(cyc, ok);
    checks++;
    if (!ok || exp_data.size() != 0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL reset_restart: done=%b beats_left=%0d cmds_left=%0d, required 1 0 0",
               ok, exp_data.size(), exp_cmd.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; int w0;
    fill_tile();
    w0 = wr_cnt;
    kick(32'h2000, 1'b0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    base_addr = 32'h5000; clear_en = 1'b1; clear_val = 32'h12345678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, ok);
    checks++;
    if (!ok || wr_cnt != w0 || exp_cmd.size() != 0 || exp_data.size() != 0) begin
      errors++;
      $display("FAIL start_busy: done=%b writes=%0d cmds_left=%0d, required 1 0 0",
               ok, wr_cnt - w0, exp_cmd.size());
    end
    kick(32'h3000, 1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.mem_cmd_valid !== 1'b1 || bus.mem_cmd_addr !== 32'h3000) begin
      errors++;
      $display("FAIL start_in_done: busy=%b cv=%b addr=%h, required 1 1 3000",
               busy, bus.mem_cmd_valid, bus.mem_cmd_addr);
    end
    wait_done(cyc, ok);
    checks++;
    if (!ok || exp_data.size() != 0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL back_to_back: done=%b beats_left=%0d, required 1 0", ok, exp_data.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; clear_en = 1'b0; clear_val = '0;
    cur_clear_val = '0;
    test_reset();
    test_basic();
    test_clear();
    test_backpressure();
    test_cmd_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
